// File: rtl/taylor_seq_ctrl.sv
// taylor_seq_ctrl
//   Sequencer for a fixed-point exp(x) Taylor series. It evaluates one term per
//   loop iteration: term *= x, then term *= 1/(n+1) from an external
//   reciprocal ROM, then sum += term. All values are Q8.8 unsigned. Every
//   multiply and add saturates to all-ones, and any saturation sets a sticky
//   flag that is reported as ovf.
//
// Ports
//   clk       in   clock, rising edge
//   rst       in   synchronous active-low reset
//   start     in   begin an evaluation (honoured only when idle)
//   x         in   operand, Q8.8, latched on an accepted start
//   terms     in   number of terms after the constant 1.0, clamped to MAX_TERMS
//   rom_adr   out  reciprocal ROM address (iteration index n)
//   rom_data  in   ROM word for rom_adr, combinational
//   busy      out  high in every state except idle
//   done      out  one-cycle pulse when result/ovf update
//   result    out  series sum, Q8.8, held until the next done
//   ovf       out  saturation occurred during the last evaluation
module taylor_seq_ctrl #(
  parameter int MAX_TERMS = 12,
  parameter int W         = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [3:0]   terms,
  output logic [3:0]   rom_adr,
  input  logic [W-1:0] rom_data,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULX,
    S_MULQ,
    S_ACC,
    S_DONE
  } state_t;

  localparam logic [W-1:0] ONE_Q88 = W'(256);
  localparam logic [W-1:0] ALL_ONE = '1;

  // Q8.8 multiply: full-precision product truncated to bits [W+7:8]. Any set
  // bit above that window means the value does not fit, so clamp and flag.
  function automatic logic [W:0] mul_sat(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = (2*W)'(a) * (2*W)'(b);
    if (p[2*W-1:W+8] != '0) return {1'b1, ALL_ONE};
    return {1'b0, p[W+7:8]};
  endfunction

  // Saturating add; carry out clamps and flags.
  function automatic logic [W:0] add_sat(input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[W]) return {1'b1, ALL_ONE};
    return s;
  endfunction

  state_t       state_q,  state_d;
  logic [3:0]   n_q,      n_d;
  logic [3:0]   nterm_q,  nterm_d;
  logic [W-1:0] x_q,      x_d;
  logic [W-1:0] term_q,   term_d;
  logic [W-1:0] sum_q,    sum_d;
  logic         sat_q,    sat_d;
  logic         busy_q,   busy_d;
  logic         done_q,   done_d;
  logic [W-1:0] result_q, result_d;
  logic         ovf_q,    ovf_d;

  logic [3:0]   nclamp;
  logic [W-1:0] mul_b;
  logic [W:0]   mul_res;
  logic [W:0]   add_res;

  assign nclamp  = (terms > 4'(MAX_TERMS)) ? 4'(MAX_TERMS) : terms;
  // One shared multiplier: x in MULX, the ROM reciprocal in MULQ.
  assign mul_b   = (state_q == S_MULQ) ? rom_data : x_q;
  assign mul_res = mul_sat(term_q, mul_b);
  assign add_res = add_sat(sum_q, term_q);

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    nterm_d  = nterm_q;
    x_d      = x_q;
    term_d   = term_q;
    sum_d    = sum_q;
    sat_d    = sat_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = x;
          nterm_d = nclamp;
          term_d  = ONE_Q88;
          sum_d   = ONE_Q88;
          n_d     = 4'd0;
          sat_d   = 1'b0;
          state_d = (nclamp == 4'd0) ? S_DONE : S_MULX;
        end
      end
      S_MULX, S_MULQ: begin
        term_d  = mul_res[W-1:0];
        sat_d   = sat_q | mul_res[W];
        state_d = (state_q == S_MULX) ? S_MULQ : S_ACC;
      end
      S_ACC: begin
        sum_d = add_res[W-1:0];
        sat_d = sat_q | add_res[W];
        // nterm_q is at least 1 here; a zero request goes straight to DONE.
        if (n_q == nterm_q - 4'd1) begin
          n_d     = 4'd0;
          state_d = S_DONE;
        end else begin
          n_d     = n_q + 4'd1;
          state_d = S_MULX;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        result_d = sum_q;
        ovf_d    = sat_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      n_q      <= 4'd0;
      nterm_q  <= 4'd0;
      x_q      <= '0;
      term_q   <= '0;
      sum_q    <= '0;
      sat_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      nterm_q  <= nterm_d;
      x_q      <= x_d;
      term_q   <= term_d;
      sum_q    <= sum_d;
      sat_q    <= sat_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rom_adr = n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign ovf     = ovf_q;

endmodule
